// File: rtl/exe_fwd_hazard_ctrl_if.sv
// ID-stage instruction fields in, forwarding selects and load-use stall out.
// The master drives ID fields; the slave is the hazard controller.
interface exe_fwd_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             pipe_hold;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_shift;
  logic             id_aluimm;
  logic             id_wreg;
  logic             id_m2reg;
  logic [REG_W-1:0] id_rd;
  logic             stall;
  logic [1:0]       exe_a_select;
  logic [1:0]       exe_b_select;
  logic             wb_m2reg;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output pipe_hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_shift, id_aluimm, id_wreg, id_m2reg, id_rd,
    input  stall, exe_a_select, exe_b_select, wb_m2reg, stall_count
  );

  modport slave (
    input  pipe_hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_shift, id_aluimm, id_wreg, id_m2reg, id_rd,
    output stall, exe_a_select, exe_b_select, wb_m2reg, stall_count
  );
endinterface

// File: rtl/exe_fwd_hazard_ctrl.sv
// Execute-stage forwarding select generator and load-use stall controller.
// Tracks EXE/MEM/WB destination flags and registers operand selects into EXE.
module exe_fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic                  clock,
  input logic                  resetn,
  exe_fwd_hazard_ctrl_if.slave bus
);

  logic             e_valid_r, e_wreg_r, e_m2reg_r;
  logic [REG_W-1:0] e_dest_r;
  logic             m_valid_r, m_wreg_r;
  logic             m_m2reg_r;
  logic [REG_W-1:0] m_dest_r;
  logic             wb_m2reg_r;
  logic [1:0]       a_sel_r, b_sel_r;
  logic [CNT_W-1:0] cnt_r;

  logic             hit_e_rs_s, hit_e_rt_s, hit_m_rs_s, hit_m_rt_s;
  logic             stall_s, bubble_s;
  logic [1:0]       a_sel_s, b_sel_s;

  // Producer match; register 0 is never a hazard.
  function automatic logic src_hit(input logic valid, input logic wreg,
                                   input logic [REG_W-1:0] dest,
                                   input logic [REG_W-1:0] src, input logic use_src);
    return valid & wreg & use_src & (src != {REG_W{1'b0}}) & (dest == src);
  endfunction

  // Youngest producer wins; an EXE load is never forwarded (it stalls instead).
  function automatic logic [1:0] pick_sel(input logic ovr, input logic hit_e,
                                          input logic e_load, input logic hit_m);
    logic [1:0] sel;
    if (ovr)                 sel = 2'b01;
    else if (hit_e & ~e_load) sel = 2'b10;
    else if (hit_m)          sel = 2'b11;
    else                     sel = 2'b00;
    return sel;
  endfunction

  assign hit_e_rs_s = src_hit(e_valid_r, e_wreg_r, e_dest_r, bus.id_rs, bus.id_use_rs);
  assign hit_e_rt_s = src_hit(e_valid_r, e_wreg_r, e_dest_r, bus.id_rt, bus.id_use_rt);
  assign hit_m_rs_s = src_hit(m_valid_r, m_wreg_r, m_dest_r, bus.id_rs, bus.id_use_rs);
  assign hit_m_rt_s = src_hit(m_valid_r, m_wreg_r, m_dest_r, bus.id_rt, bus.id_use_rt);

  assign stall_s  = bus.id_valid & ~bus.pipe_hold & e_m2reg_r & (hit_e_rs_s | hit_e_rt_s);
  assign bubble_s = stall_s | ~bus.id_valid;
  assign a_sel_s  = pick_sel(bus.id_shift,  hit_e_rs_s, e_m2reg_r, hit_m_rs_s);
  assign b_sel_s  = pick_sel(bus.id_aluimm, hit_e_rt_s, e_m2reg_r, hit_m_rt_s);

  // Pipeline tracking, registered selects and saturating stall counter.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      e_valid_r  <= 1'b0;
      e_wreg_r   <= 1'b0;
      e_m2reg_r  <= 1'b0;
      e_dest_r   <= {REG_W{1'b0}};
      m_valid_r  <= 1'b0;
      m_wreg_r   <= 1'b0;
      m_m2reg_r  <= 1'b0;
      m_dest_r   <= {REG_W{1'b0}};
      wb_m2reg_r <= 1'b0;
      a_sel_r    <= 2'b00;
      b_sel_r    <= 2'b00;
      cnt_r      <= {CNT_W{1'b0}};
    end else if (!bus.pipe_hold) begin
      wb_m2reg_r <= m_valid_r & m_m2reg_r;
      m_valid_r  <= e_valid_r;
      m_wreg_r   <= e_wreg_r;
      m_m2reg_r  <= e_m2reg_r;
      m_dest_r   <= e_dest_r;
      if (bubble_s) begin
        e_valid_r <= 1'b0;
        e_wreg_r  <= 1'b0;
        e_m2reg_r <= 1'b0;
        e_dest_r  <= {REG_W{1'b0}};
        a_sel_r   <= 2'b00;
        b_sel_r   <= 2'b00;
      end else begin
        e_valid_r <= 1'b1;
        e_wreg_r  <= bus.id_wreg;
        e_m2reg_r <= bus.id_m2reg;
        e_dest_r  <= bus.id_rd;
        a_sel_r   <= a_sel_s;
        b_sel_r   <= b_sel_s;
      end
      if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.stall        = stall_s;
  assign bus.exe_a_select = a_sel_r;
  assign bus.exe_b_select = b_sel_r;
  assign bus.wb_m2reg     = wb_m2reg_r;
  assign bus.stall_count  = cnt_r;

endmodule

// File: tb/tb_exe_fwd_hazard_ctrl.sv
// Bench for exe_fwd_hazard_ctrl: directed hazard scenarios with literal
// expectations, then random instruction streams against a pipeline-list model.
module tb_exe_fwd_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clock;
  logic resetn;
  logic chk_en;
  int   n_cmp = 0;
  int   n_bad = 0;

  exe_fwd_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
  exe_fwd_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // In-flight instruction list: index 0 = EXE, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic       v;
    logic       w;
    logic       ld;
    logic [4:0] d;
    logic [1:0] a;
    logic [1:0] b;
  } rec_t;

  rec_t mp[3];
  int   mcnt;

  // Operand source: override, else nearest older writer in EXE(10) or MEM(11).
  function automatic logic [1:0] exp_sel(input logic ovr, input logic [4:0] s, input logic u);
    if (ovr) return 2'b01;
    if (!u || s == 5'd0) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (mp[i].v && mp[i].w && mp[i].d == s) return (i == 0) ? 2'b10 : 2'b11;
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    logic need;
    need = (bus.id_use_rs && bus.id_rs != 5'd0 && mp[0].d == bus.id_rs) ||
           (bus.id_use_rt && bus.id_rt != 5'd0 && mp[0].d == bus.id_rt);
    return bus.id_valid && !bus.pipe_hold && mp[0].v && mp[0].w && mp[0].ld && need;
  endfunction

  always @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) mp[i] <= '0;
      mcnt <= 0;
    end else if (!bus.pipe_hold) begin
      mp[2] <= mp[1];
      mp[1] <= mp[0];
      if (exp_stall() || !bus.id_valid)
        mp[0] <= '0;
      else
        mp[0] <= '{v: 1'b1, w: bus.id_wreg, ld: bus.id_m2reg, d: bus.id_rd,
                   a: exp_sel(bus.id_shift, bus.id_rs, bus.id_use_rs),
                   b: exp_sel(bus.id_aluimm, bus.id_rt, bus.id_use_rt)};
      if (exp_stall() && mcnt < CNT_MAX) mcnt <= mcnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_stall", {31'd0, bus.stall}, {31'd0, exp_stall()});
      chk("m_asel", {30'd0, bus.exe_a_select}, {30'd0, mp[0].a});
      chk("m_bsel", {30'd0, bus.exe_b_select}, {30'd0, mp[0].b});
      chk("m_wbld", {31'd0, bus.wb_m2reg}, {31'd0, mp[2].v & mp[2].ld});
      chk("m_cnt", {28'd0, bus.stall_count}, mcnt);
    end
  end

  task automatic put(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic sh, input logic imm,
                     input logic wr, input logic ld, input logic [4:0] rd);
    bus.id_valid = v;   bus.id_rs = rs;      bus.id_rt = rt;
    bus.id_use_rs = urs; bus.id_use_rt = urt; bus.id_shift = sh;
    bus.id_aluimm = imm; bus.id_wreg = wr;    bus.id_m2reg = ld; bus.id_rd = rd;
  endtask

  task automatic nop();
    put(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic go();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic flush();
    repeat (3) begin go(); nop(); end
  endtask

  task automatic lit_outs(input string nm, input logic [1:0] a, input logic [1:0] b,
                          input logic wb, input logic st, input int cnt);
    chk({nm, "_a"}, {30'd0, bus.exe_a_select}, {30'd0, a});
    chk({nm, "_b"}, {30'd0, bus.exe_b_select}, {30'd0, b});
    chk({nm, "_wb"}, {31'd0, bus.wb_m2reg}, {31'd0, wb});
    chk({nm, "_stall"}, {31'd0, bus.stall}, {31'd0, st});
    chk({nm, "_cnt"}, {28'd0, bus.stall_count}, cnt);
  endtask

  initial begin
    clock = 1'b0;
    resetn = 1'b0;
    chk_en = 1'b0;
    bus.pipe_hold = 1'b0;
    nop();
    repeat (2) @(posedge clock);
    #1;
    chk_en = 1'b1;
    sample();
    lit_outs("reset", 2'b00, 2'b00, 1'b0, 1'b0, 0);

    // add r3 ; add r4,r3,r5 -> EXE forward on a
    go(); resetn = 1'b1; put(1, 5'd1, 5'd1, 1, 1, 0, 0, 1, 0, 5'd3);
    go(); put(1, 5'd3, 5'd5, 1, 1, 0, 0, 1, 0, 5'd4);
    sample(); chk("fwd_e_stall", {31'd0, bus.stall}, 32'd0);
    go(); nop();
    sample(); chk("fwd_e_a", {30'd0, bus.exe_a_select}, 32'd2);
    chk("fwd_e_b", {30'd0, bus.exe_b_select}, 32'd0);
    flush();

    // add r3 ; nop ; sub r6,r7,r3 -> MEM forward on b
    go(); put(1, 5'd1, 5'd1, 1, 1, 0, 0, 1, 0, 5'd3);
    go(); nop();
    go(); put(1, 5'd7, 5'd3, 1, 1, 0, 0, 1, 0, 5'd6);
    sample(); chk("fwd_m_stall", {31'd0, bus.stall}, 32'd0);
    go(); nop();
    sample(); lit_outs("fwd_m", 2'b00, 2'b11, 1'b0, 1'b0, 0);
    flush();

    // lw r2 ; add r8,r2,r2 -> one bubble then WB-data selects
    go(); put(1, 5'd1, 5'd0, 1, 0, 0, 1, 1, 1, 5'd2);
    go(); put(1, 5'd2, 5'd2, 1, 1, 0, 0, 1, 0, 5'd8);
    sample(); chk("lu_stall1", {31'd0, bus.stall}, 32'd1);
    go();
    sample(); lit_outs("lu_bubble", 2'b00, 2'b00, 1'b0, 1'b0, 1);
    go(); nop();
    sample(); lit_outs("lu_use", 2'b11, 2'b11, 1'b1, 1'b0, 1);
    flush();

    // r0 never forwarded or stalled on; sll takes sa on a
    go(); put(1, 5'd1, 5'd1, 1, 1, 0, 0, 1, 0, 5'd0);
    go(); put(1, 5'd0, 5'd0, 1, 1, 0, 0, 1, 0, 5'd10);
    sample(); chk("r0_stall", {31'd0, bus.stall}, 32'd0);
    go(); nop();
    sample(); lit_outs("r0_alu", 2'b00, 2'b00, 1'b0, 1'b0, 1);
    go(); put(1, 5'd1, 5'd0, 1, 0, 0, 1, 1, 1, 5'd0);
    go(); put(1, 5'd0, 5'd0, 1, 1, 0, 0, 1, 0, 5'd11);
    sample(); chk("r0_ld_stall", {31'd0, bus.stall}, 32'd0);
    go(); put(1, 5'd0, 5'd4, 0, 1, 1, 0, 1, 0, 5'd12);
    go(); nop();
    sample(); chk("sll_a", {30'd0, bus.exe_a_select}, 32'd1);
    flush();

    // fresh reset, then load-use with a 3-cycle freeze during the stall
    go(); resetn = 1'b0;
    go(); go(); resetn = 1'b1;
    go(); put(1, 5'd1, 5'd0, 1, 0, 0, 1, 1, 1, 5'd2);
    go(); put(1, 5'd2, 5'd1, 1, 1, 0, 0, 1, 0, 5'd9); bus.pipe_hold = 1'b1;
    sample(); chk("hold_stall0", {31'd0, bus.stall}, 32'd0);
    go(); go();
    sample(); lit_outs("hold_frozen", 2'b00, 2'b01, 1'b0, 1'b0, 0);
    go(); bus.pipe_hold = 1'b0;
    sample(); chk("hold_stall1", {31'd0, bus.stall}, 32'd1);
    go();
    sample(); lit_outs("hold_bubble", 2'b00, 2'b00, 1'b0, 1'b0, 1);
    go(); nop();
    sample(); lit_outs("hold_use", 2'b11, 2'b00, 1'b1, 1'b0, 1);

    // reset in the middle of a pending load-use stall
    go(); put(1, 5'd1, 5'd0, 1, 0, 0, 1, 1, 1, 5'd2);
    go(); put(1, 5'd2, 5'd0, 1, 0, 0, 0, 1, 0, 5'd9);
    sample(); chk("mid_stall", {31'd0, bus.stall}, 32'd1);
    go(); resetn = 1'b0;
    go();
    sample(); lit_outs("mid_reset", 2'b00, 2'b00, 1'b0, 1'b0, 0);
    go(); resetn = 1'b1;
    flush();

    // random streams over a small register set to provoke many hazards
    for (int n = 0; n < 3000; n++) begin
      go();
      resetn = ($urandom_range(0, 599) != 0);
      bus.pipe_hold = ($urandom_range(0, 4) == 0);
      put($urandom_range(0, 6) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)));
    end
    go();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
